// File: rtl/ssd_digit_scanner.sv
// Four-digit multiplexed seven-segment scanner: cycles DRIVE/BLANK per digit,
// double-buffers new values so the display only changes at a frame boundary.
module ssd_digit_scanner #(
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        value_valid,
  output logic        value_ready,
  input  logic        lz_blank,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {
    S_DRIVE = 1'b0,
    S_BLANK = 1'b1
  } state_t;

  logic [CW-1:0] r_cnt;
  logic          w_tick;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_d, w_d_nxt;
  logic          w_wrap;

  logic [15:0]   r_pend;
  logic          r_pend_full;
  logic [15:0]   r_disp;
  logic [15:0]   w_disp_nxt;
  logic          w_accept;
  logic          w_load_disp;

  logic [3:0]    w_hi_zero;
  logic [3:0]    w_digit;

  logic [3:0]    r_an;
  logic [3:0]    r_bcd;
  logic          r_fs;

  assign w_tick = (r_cnt == CW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + CW'(1);
  end

  // Reset parks in BLANK(3) so the first tick is a frame wrap into DRIVE(0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BLANK;
      r_d     <= 2'd3;
    end else begin
      r_state <= w_state_nxt;
      r_d     <= w_d_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_d_nxt     = r_d;
    w_wrap      = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_DRIVE: w_state_nxt = S_BLANK;
        S_BLANK: begin
          w_state_nxt = S_DRIVE;
          w_d_nxt     = r_d + 2'd1;
          w_wrap      = (r_d == 2'd3);
        end
        default: w_state_nxt = S_BLANK;
      endcase
    end
  end

  assign value_ready = !r_pend_full;
  assign w_accept    = value_valid && !r_pend_full;
  assign w_load_disp = w_wrap && r_pend_full;
  assign w_disp_nxt  = w_load_disp ? r_pend : r_disp;

  // An accept on the wrap tick only sees an empty buffer, so it stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= 16'h0000;
      r_pend_full <= 1'b0;
      r_disp      <= 16'h0000;
    end else begin
      if (w_accept) begin
        r_pend      <= value;
        r_pend_full <= 1'b1;
      end else if (w_load_disp) begin
        r_pend_full <= 1'b0;
      end
      r_disp <= w_disp_nxt;
    end
  end

  // w_hi_zero[i]: digit i and everything above it are zero; digit0 never blanks.
  assign w_hi_zero[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 1; gi < 4; gi++) begin : g_hz
      assign w_hi_zero[gi] = (w_disp_nxt[15:4*gi] == '0);
    end
  endgenerate

  assign w_digit = w_disp_nxt[{w_d_nxt, 2'b00} +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 4'b1111;
      r_bcd <= 4'hF;
      r_fs  <= 1'b0;
    end else begin
      r_fs <= w_tick && w_wrap;
      if (w_tick) begin
        if (w_state_nxt == S_DRIVE) begin
          r_an  <= ~(4'b0001 << w_d_nxt);
          r_bcd <= (lz_blank && w_hi_zero[w_d_nxt]) ? 4'hF : w_digit;
        end else begin
          r_an  <= 4'b1111;
          r_bcd <= 4'hF;
        end
      end
    end
  end

  assign an          = r_an;
  assign bcd         = r_bcd;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_ssd_digit_scanner.sv
// Directed bench for ssd_digit_scanner at PRESCALE=4: frame capture against
// hand-computed per-digit bcd values, plus buffering and reset corner cases.
module tb_ssd_digit_scanner;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        value_valid;
  logic        value_ready;
  logic        lz_blank;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  ssd_digit_scanner #(.PRESCALE(P)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .lz_blank    (lz_blank),
    .bcd         (bcd),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] val;
    logic        lz;
    logic [15:0] exp;  // expected bcd per digit, nibble d = digit d
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_fs(input string nm);
    int n = 0;
    @(negedge clk);
    while (!frame_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!frame_start) begin
      failures++;
      $display("FAIL %s: frame_start timeout got 0 expected 1", nm);
    end
  endtask

  // Called at the negedge where frame_start is visible; samples first cycle of each slot.
  task automatic capture(input string tag, input logic [15:0] exp);
    logic [3:0] ea, eb;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) repeat (P) @(negedge clk);
      if (k % 2 == 0) begin
        ea = ~(4'b0001 << (k / 2));
        eb = exp[4*(k/2) +: 4];
      end else begin
        ea = 4'b1111;
        eb = 4'hF;
      end
      chk($sformatf("%s an slot%0d", tag, k), {12'h0, an}, {12'h0, ea});
      chk($sformatf("%s bcd slot%0d", tag, k), {12'h0, bcd}, {12'h0, eb});
      chk($sformatf("%s fs slot%0d", tag, k), {15'h0, frame_start}, {15'h0, (k == 0)});
    end
  endtask

  initial begin
    vecs[0] = '{"v1234",  16'h1234, 1'b0, 16'h1234};
    vecs[1] = '{"v0070",  16'h0070, 1'b1, 16'hFF70};
    vecs[2] = '{"v0000z", 16'h0000, 1'b1, 16'hFFF0};
    vecs[3] = '{"vA05B",  16'hA05B, 1'b1, 16'hA05B};
    vecs[4] = '{"v0000",  16'h0000, 1'b0, 16'h0000};
    vecs[5] = '{"v0102",  16'h0102, 1'b1, 16'hF102};

    rst_n = 1'b0; value = 16'h0; value_valid = 1'b0; lz_blank = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst an",    {12'h0, an},  16'h000F);
    chk("rst bcd",   {12'h0, bcd}, 16'h000F);
    chk("rst fs",    {15'h0, frame_start}, 16'h0);
    chk("rst ready", {15'h0, value_ready}, 16'h1);

    // First P cycles after release stay dark, then frame 0 begins.
    rst_n = 1'b1;
    for (int i = 0; i < P - 1; i++) begin
      @(negedge clk);
      chk($sformatf("post-rst an c%0d", i), {12'h0, an}, 16'h000F);
      chk($sformatf("post-rst fs c%0d", i), {15'h0, frame_start}, 16'h0);
    end
    @(negedge clk);
    capture("first", 16'h0000);

    for (int v = 0; v < 6; v++) begin
      wait_fs({vecs[v].name, " sync"});
      value = vecs[v].val; lz_blank = vecs[v].lz; value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      chk({vecs[v].name, " ready low"}, {15'h0, value_ready}, 16'h0);
      wait_fs({vecs[v].name, " wrap"});
      chk({vecs[v].name, " ready back"}, {15'h0, value_ready}, 16'h1);
      capture(vecs[v].name, vecs[v].exp);
    end

    // Accept on the wrap tick itself: shown only at the following wrap.
    wait_fs("wraptick sync");
    repeat (8*P - 1) @(negedge clk);
    value = 16'h4321; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    chk("wraptick fs",    {15'h0, frame_start}, 16'h1);
    chk("wraptick ready", {15'h0, value_ready}, 16'h0);
    capture("wraptick old", 16'hF102);
    wait_fs("wraptick new sync");
    capture("wraptick new", 16'h4321);

    // Hold valid with changing data while full; 9999 is taken only after the wrap.
    wait_fs("hold sync");
    value = 16'h1111; value_valid = 1'b1;
    @(negedge clk);
    value = 16'h5555;
    chk("hold ready0", {15'h0, value_ready}, 16'h0);
    begin
      int n = 0;
      while (!frame_start && n < 200) begin
        @(negedge clk);
        value = n[0] ? 16'h5555 : 16'h7777;
        n++;
        if (n == 5) chk("hold ready mid", {15'h0, value_ready}, 16'h0);
      end
    end
    chk("hold wrap fs",    {15'h0, frame_start}, 16'h1);
    chk("hold wrap ready", {15'h0, value_ready}, 16'h1);
    value = 16'h9999;
    fork
      begin @(negedge clk); value_valid = 1'b0; end
    join_none
    capture("hold 1111", 16'h1111);
    wait_fs("hold 9999 sync");
    capture("hold 9999", 16'h9999);

    // Async reset during DRIVE(2) with a load pending.
    lz_blank = 1'b0;
    wait_fs("midrst sync");
    value = 16'h2222; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    repeat (4*P) @(negedge clk);
    chk("midrst an drive2", {12'h0, an}, 16'h000B);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst an",    {12'h0, an},  16'h000F);
    chk("midrst bcd",   {12'h0, bcd}, 16'h000F);
    chk("midrst fs",    {15'h0, frame_start}, 16'h0);
    chk("midrst ready", {15'h0, value_ready}, 16'h1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fs("midrst frame1");
    chk("midrst ready after", {15'h0, value_ready}, 16'h1);
    capture("midrst f1", 16'h0000);
    wait_fs("midrst frame2");
    capture("midrst f2", 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssd_digit_scanner.md
SSD_DIGIT_SCANNER -- requirements
Module: ssd_digit_scanner

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000, meaning clock cycles per scan tick (legal range >= 2).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning the reset; asynchronous, active-low.
REQ-004 SHALL have port value, input, 16, meaning four packed BCD digits; digit0 = [3:0] (rightmost) through digit3 = [15:12].
REQ-005 SHALL have port value_valid, input, 1, meaning value is offered this cycle.
REQ-006 SHALL have port value_ready, output, 1, meaning the block can accept value this cycle.
REQ-007 SHALL have port lz_blank, input, 1, meaning leading-zero blanking is enabled.
REQ-008 SHALL have port bcd, output, 4, meaning the nibble sent to the downstream BCD-to-seven-segment decoder; 4'hF means blank, because the decoder blanks all codes above 9.
REQ-009 SHALL have port an, output, 4, meaning active-low digit enables; an[i] drives digit i.
REQ-010 SHALL have port frame_start, output, 1, meaning a one-cycle pulse when digit0 drive begins.

Function
REQ-011 SHALL count the prescaler from 0 to PRESCALE-1 and wrap; tick = 1 in the cycle the count equals PRESCALE-1.
REQ-012 SHALL implement a two-state FSM, DRIVE and BLANK, together with a 2-bit digit index d; every transition happens only on tick.
REQ-013 SHALL transition DRIVE(d) -> BLANK(d), and BLANK(d) -> DRIVE(d+1 mod 4); BLANK(3) -> DRIVE(0) is the frame wrap.
REQ-014 SHALL, in DRIVE(d), register an with only bit d low and bcd = digit d of the display register, or 4'hF when that digit is blanked.
REQ-015 SHALL, in BLANK, register an = 4'b1111 and bcd = 4'hF (anti-ghosting gap).
REQ-016 SHALL blank digit d (d in 1..3) when lz_blank = 1 and digit d and all higher digits of the display register equal 0; digit0 is never blanked.
REQ-017 SHALL pass any digit nibble greater than 9 through to bcd unchanged; it is not treated as zero for blanking.
REQ-018 SHALL hold one pending register and a pending_full flag; value_ready = !pending_full, driven combinationally from that flag.
REQ-019 SHALL, when value_valid && value_ready, load pending <= value and set pending_full = 1 in the same cycle.
REQ-020 SHALL, on the frame-wrap tick with pending_full = 1, copy pending into the display register and clear pending_full; the display register never changes mid-frame.
REQ-021 SHALL keep an accept that coincides with the frame-wrap tick in pending; it is displayed at the next frame wrap.
REQ-022 SHALL ignore value while value_ready = 0; value_valid held high with changing data SHALL NOT alter pending.
REQ-023 SHALL assert frame_start for exactly the one cycle in which an first shows 4'b1110 of each frame.
REQ-024 SHALL register all outputs except value_ready; bcd and an change only in the cycle after tick; each state lasts PRESCALE cycles; a frame lasts 8*PRESCALE cycles.
REQ-025 SHALL sample lz_blank in the tick cycle on entry to DRIVE; the sampled value applies for that whole digit slot.

Reset
REQ-026 SHALL, while rst_n = 0, force: prescaler = 0, state = BLANK, d = 3, display = 16'h0000, pending_full = 0, an = 4'b1111, bcd = 4'hF, frame_start = 0, value_ready = 1.
REQ-027 SHALL make the first tick after reset release a frame wrap, so DRIVE(0) is the first digit shown.
REQ-028 SHALL, on reset asserted mid-frame or with a load pending, discard the pending value and apply REQ-026 immediately without waiting for clk.

Verification
REQ-029 Reset release, PRESCALE=4, lz_blank=0 -> an=1111 for cycles 0-3, then frame_start pulse, an=1110 with bcd=0; the pattern 1110/1111/1101/1111/1011/1111/0111/1111 repeats with 4 cycles per step.
REQ-030 Load 16'h1234 mid-frame -> value_ready falls the next cycle; the current frame still shows 0000; the next frame shows bcd 4,3,2,1 on an[0..3]; value_ready returns to 1 at the wrap.
REQ-031 lz_blank=1, value 16'h0070 -> digit3 = F, digit2 = F, digit1 = 7, digit0 = 0; value 16'h0000 -> only digit0 shows 0.
REQ-032 Second value 16'h9999 offered while pending_full -> not accepted, value_ready stays 0; after the wrap it is accepted and displayed one frame later.
REQ-033 Value 16'hA05B, lz_blank=1 -> digit0 bcd=B, digit1=5, digit2=0 (not blanked, because a higher digit is nonzero), digit3=A.
REQ-034 rst_n pulsed low during DRIVE(2) with a load pending -> outputs reach reset values asynchronously; after release, display shows 0000 and value_ready = 1.
